othello_job_sched: RTL and testbench

OTHELLO_JOB_SCHED -- requirements
Module: othello_job_sched

---
 rtl/othello_pkg.sv | 16 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/othello_job_sched.sv | 191 +++++++++++++++++++
 tb/tb_othello_job_sched.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// Shared scheduler state encoding and filler-board constants for the Othello job scheduler.
package othello_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int SOL_CTX_W = 5;

  // A board with every square owned by the player and none by the opponent is never a legal root.
  localparam logic [63:0] FILLER_PLAYER   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FILLER_OPPONENT = 64'h0000_0000_0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered empty/full flags and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         iCLOCK,
  input  logic                         iRESET_N,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_next;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(DEPTH));
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/othello_job_sched.sv
// Feeds queued Othello root boards to an interleaved multi-context solver and collects tagged scores.
// Optional statistics counters are enabled by defining JOB_SCHED_STATS_EN.
module othello_job_sched
  import othello_pkg::*;
#(
  parameter int NCTX   = 7,
  parameter int QDEPTH = 4,
  parameter int RDEPTH = 8,
  parameter int TAG_W  = 8
) (
  input  logic                 iCLOCK,
  input  logic                 iRESET_N,
  input  logic                 iRUN,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_player,
  input  logic [63:0]          in_opponent,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic signed [7:0]    out_score,
  output logic                 sol_enable,
  output logic [63:0]          sol_player,
  output logic [63:0]          sol_opponent,
  input  logic                 sol_take,
  input  logic                 sol_solved,
  input  logic [SOL_CTX_W-1:0] sol_ctx,
  input  logic signed [7:0]    sol_res,
  output logic                 busy
`ifdef JOB_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_done,
  output logic [31:0]          stat_busy
`endif
);

  localparam int JOB_W = 128 + TAG_W;
  localparam int RES_W = TAG_W + 8;
  localparam int CTX_W = (NCTX > 1) ? $clog2(NCTX) : 1;
  localparam int IF_W  = $clog2(NCTX + 1);
  localparam int QC_W  = $clog2(QDEPTH + 1);
  localparam int RC_W  = $clog2(RDEPTH + 1);

  sched_state_t      state;
  logic              ready_q;

  logic [JOB_W-1:0]  jq_head;
  logic              jq_empty;
  logic              jq_full;
  logic [QC_W-1:0]   jq_count;
  logic              jq_push;
  logic              jq_pop;
  logic [TAG_W-1:0]  jq_tag;
  logic [63:0]       jq_player;
  logic [63:0]       jq_opponent;

  logic [RES_W-1:0]  rf_head;
  logic              rf_empty;
  logic              rf_full;
  logic [RC_W-1:0]   rf_count;
  logic              rf_push;
  logic              rf_pop;

  logic [NCTX-1:0]   ctx_live;
  logic [TAG_W-1:0]  ctx_tag [NCTX];
  logic [IF_W-1:0]   inflight;
  logic              credit_ok;
  logic              dispatch;
  logic              ctx_ok;
  logic [CTX_W-1:0]  ctx_idx;
  logic              take_ok;
  logic              solve_ok;

  assign in_ready    = ready_q & ~jq_full;
  assign jq_push     = in_valid & in_ready;
  assign jq_player   = jq_head[JOB_W-1 -: 64];
  assign jq_opponent = jq_head[TAG_W +: 64];
  assign jq_tag      = jq_head[TAG_W-1:0];

  sync_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (QDEPTH)
  ) u_job_queue (
    .iCLOCK    (iCLOCK),
    .iRESET_N  (iRESET_N),
    .push      (jq_push),
    .push_data ({in_player, in_opponent, in_tag}),
    .pop       (jq_pop),
    .head      (jq_head),
    .empty     (jq_empty),
    .full      (jq_full),
    .count     (jq_count)
  );

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NCTX; i++) begin
      inflight = inflight + IF_W'(ctx_live[i]);
    end
  end

  // Every live context may still retire a result, so it holds a result-FIFO slot in reserve.
  assign credit_ok = (32'(inflight) + 32'(rf_count)) < 32'(RDEPTH);
  assign dispatch  = (state == RUN) & ~jq_empty & credit_ok;

  assign ctx_ok   = 32'(sol_ctx) < 32'(NCTX);
  assign ctx_idx  = sol_ctx[CTX_W-1:0];
  assign take_ok  = sol_take & ctx_ok;
  assign solve_ok = sol_solved & ctx_ok;
  assign jq_pop   = take_ok & dispatch;
  assign rf_push  = solve_ok & ctx_live[ctx_idx];

  assign sol_player   = dispatch ? jq_player   : FILLER_PLAYER;
  assign sol_opponent = dispatch ? jq_opponent : FILLER_OPPONENT;

  sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RDEPTH)
  ) u_result_fifo (
    .iCLOCK    (iCLOCK),
    .iRESET_N  (iRESET_N),
    .push      (rf_push),
    .push_data ({ctx_tag[ctx_idx], sol_res}),
    .pop       (rf_pop),
    .head      (rf_head),
    .empty     (rf_empty),
    .full      (rf_full),
    .count     (rf_count)
  );

  assign out_valid = ~rf_empty;
  assign rf_pop    = out_valid & out_ready;
  assign out_tag   = out_valid ? rf_head[RES_W-1 -: TAG_W] : '0;
  assign out_score = out_valid ? signed'(rf_head[7:0]) : 8'sd0;
  assign busy      = (state != IDLE);

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      state      <= IDLE;
      sol_enable <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      sol_enable <= (state != IDLE);
      case (state)
        IDLE:    if (iRUN) state <= RUN;
        RUN:     if (!iRUN) state <= DRAIN;
        DRAIN: begin
          if (iRUN)                 state <= RUN;
          else if (inflight == '0)  state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The take is written after the retire so a same-context pair retires the old entry first.
  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      ctx_live <= '0;
    end else begin
      if (solve_ok) ctx_live[ctx_idx] <= 1'b0;
      if (take_ok)  ctx_live[ctx_idx] <= dispatch;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (jq_pop) ctx_tag[ctx_idx] <= jq_tag;
  end

`ifdef JOB_SCHED_STATS_EN
  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      stat_done <= '0;
      stat_busy <= '0;
    end else begin
      stat_done <= stat_done + 32'(rf_pop);
      stat_busy <= stat_busy + 32'(sol_enable);
    end
  end
`endif

  a_result_no_overflow: assert property (@(posedge iCLOCK) disable iff (!iRESET_N)
    !(rf_push && rf_full));
  a_ctx_in_range: assert property (@(posedge iCLOCK) disable iff (!iRESET_N)
    !((sol_take || sol_solved) && !ctx_ok));
  a_queue_bound: assert property (@(posedge iCLOCK) disable iff (!iRESET_N)
    jq_count <= QC_W'(QDEPTH));

endmodule

// File: tb/tb_othello_job_sched.sv
// Scoreboard bench for othello_job_sched: directed jobs, expected results queued and checked by a monitor.
module tb_othello_job_sched;
  import othello_pkg::*;

  typedef struct packed {
    logic [7:0] tag;
    logic [7:0] score;
  } result_t;

  logic              iCLOCK = 1'b0;
  logic              iRESET_N;
  logic              iRUN;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_player;
  logic [63:0]       in_opponent;
  logic [7:0]        in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_tag;
  logic signed [7:0] out_score;
  logic              sol_enable;
  logic [63:0]       sol_player;
  logic [63:0]       sol_opponent;
  logic              sol_take;
  logic              sol_solved;
  logic [4:0]        sol_ctx;
  logic signed [7:0] sol_res;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  result_t exp_q[$];

  othello_job_sched #(
    .NCTX   (7),
    .QDEPTH (4),
    .RDEPTH (8),
    .TAG_W  (8)
  ) dut (
    .iCLOCK       (iCLOCK),
    .iRESET_N     (iRESET_N),
    .iRUN         (iRUN),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_player    (in_player),
    .in_opponent  (in_opponent),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_tag      (out_tag),
    .out_score    (out_score),
    .sol_enable   (sol_enable),
    .sol_player   (sol_player),
    .sol_opponent (sol_opponent),
    .sol_take     (sol_take),
    .sol_solved   (sol_solved),
    .sol_ctx      (sol_ctx),
    .sol_res      (sol_res),
    .busy         (busy)
  );

  always #5 iCLOCK = ~iCLOCK;

  function automatic logic [63:0] bp(input logic [7:0] t);
    return {8{t}};
  endfunction

  function automatic logic [63:0] bo(input logic [7:0] t);
    logic [7:0] n;
    n = ~t;
    return {8{n}};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic expectResult(input logic [7:0] tag, input logic signed [7:0] score);
    exp_q.push_back({tag, score});
  endtask

  task automatic pushJob(input logic [7:0] tag, input logic [63:0] p, input logic [63:0] o);
    int waited;
    in_valid    = 1'b1;
    in_tag      = tag;
    in_player   = p;
    in_opponent = o;
    waited      = 0;
    @(negedge iCLOCK);
    while (!in_ready && waited < 20) begin
      @(negedge iCLOCK);
      waited++;
    end
    checkOutput("push_accept", {63'h0, in_ready}, 64'h1);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic take, input logic solved, input logic [4:0] ctx,
                               input logic signed [7:0] res);
    sol_take   = take;
    sol_solved = solved;
    sol_ctx    = ctx;
    sol_res    = res;
    @(negedge iCLOCK);
  endtask

  task automatic releaseStimulus();
    cycle();
    sol_take   = 1'b0;
    sol_solved = 1'b0;
  endtask

  task automatic takeJob(input logic [4:0] ctx, input logic [63:0] exp_p, input logic [63:0] exp_o);
    applyStimulus(1'b1, 1'b0, ctx, 8'sd0);
    checkOutput("take_player", sol_player, exp_p);
    checkOutput("take_opponent", sol_opponent, exp_o);
    releaseStimulus();
  endtask

  task automatic solveJob(input logic [4:0] ctx, input logic signed [7:0] res,
                          input logic emit, input logic [7:0] tag);
    if (emit) expectResult(tag, res);
    applyStimulus(1'b0, 1'b1, ctx, res);
    releaseStimulus();
  endtask

  // Monitor: every accepted output must match the oldest expected result.
  always @(negedge iCLOCK) begin : monitor
    result_t e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_output: got tag %h score %0d, expected no output", out_tag, out_score);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_tag", {56'h0, out_tag}, {56'h0, e.tag});
        checkOutput("out_score", {56'h0, out_score}, {56'h0, e.score});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    iRESET_N    = 1'b0;
    iRUN        = 1'b0;
    in_valid    = 1'b0;
    in_player   = '0;
    in_opponent = '0;
    in_tag      = '0;
    out_ready   = 1'b1;
    sol_take    = 1'b0;
    sol_solved  = 1'b0;
    sol_ctx     = '0;
    sol_res     = '0;

    // Reset values and in_ready rising one edge after release
    @(negedge iCLOCK);
    checkOutput("rst_in_ready", {63'h0, in_ready}, 64'h0);
    checkOutput("rst_out_valid", {63'h0, out_valid}, 64'h0);
    checkOutput("rst_busy", {63'h0, busy}, 64'h0);
    checkOutput("rst_sol_enable", {63'h0, sol_enable}, 64'h0);
    checkOutput("rst_out_tag", {56'h0, out_tag}, 64'h0);
    checkOutput("rst_out_score", {56'h0, out_score}, 64'h0);
    cycle();
    iRESET_N = 1'b1;
    @(negedge iCLOCK);
    checkOutput("in_ready_pre_edge", {63'h0, in_ready}, 64'h0);
    cycle();
    @(negedge iCLOCK);
    checkOutput("in_ready_post_edge", {63'h0, in_ready}, 64'h1);
    cycle();

    // Single job end to end with one-cycle result latency
    iRUN = 1'b1;
    pushJob(8'h11, 64'h0000_0008_1000_0000, 64'h0000_0010_0800_0000);
    applyStimulus(1'b1, 1'b0, 5'd3, 8'sd0);
    checkOutput("basic_player", sol_player, 64'h0000_0008_1000_0000);
    checkOutput("basic_opponent", sol_opponent, 64'h0000_0010_0800_0000);
    checkOutput("basic_busy", {63'h0, busy}, 64'h1);
    releaseStimulus();
    expectResult(8'h11, 8'sd4);
    applyStimulus(1'b0, 1'b1, 5'd3, 8'sd4);
    checkOutput("sol_enable_run", {63'h0, sol_enable}, 64'h1);
    checkOutput("latency_pre", {63'h0, out_valid}, 64'h0);
    releaseStimulus();
    @(negedge iCLOCK);
    checkOutput("latency_one", {63'h0, out_valid}, 64'h1);
    cycle();
    @(negedge iCLOCK);
    checkOutput("basic_drained", {63'h0, out_valid}, 64'h0);
    cycle();

    // Empty queue: filler on take, stale solve discarded
    takeJob(5'd0, FILLER_PLAYER, FILLER_OPPONENT);
    solveJob(5'd0, 8'sd64, 1'b0, 8'h00);
    @(negedge iCLOCK);
    checkOutput("discard_no_valid", {63'h0, out_valid}, 64'h0);
    cycle();

    // Credit limit with a stalled result port
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pushJob(8'(8'h20 + i), bp(8'(8'h20 + i)), bo(8'(8'h20 + i)));
      takeJob(5'(i), bp(8'(8'h20 + i)), bo(8'(8'h20 + i)));
    end
    solveJob(5'd0, -8'sd3, 1'b1, 8'h20);
    pushJob(8'h27, bp(8'h27), bo(8'h27));
    takeJob(5'd0, bp(8'h27), bo(8'h27));
    pushJob(8'h28, bp(8'h28), bo(8'h28));
    pushJob(8'h29, bp(8'h29), bo(8'h29));
    solveJob(5'd1, 8'sd12, 1'b1, 8'h21);
    takeJob(5'd1, FILLER_PLAYER, FILLER_OPPONENT);
    repeat (3) begin
      @(negedge iCLOCK);
      checkOutput("stall_out_valid", {63'h0, out_valid}, 64'h1);
      checkOutput("stall_in_ready", {63'h0, in_ready}, 64'h1);
    end
    cycle();
    out_ready = 1'b1;
    repeat (3) cycle();
    takeJob(5'd1, bp(8'h28), bo(8'h28));

    // Same-cycle retire and take on context 5
    expectResult(8'h25, -8'sd64);
    applyStimulus(1'b1, 1'b1, 5'd5, -8'sd64);
    checkOutput("same_ctx_player", sol_player, bp(8'h29));
    releaseStimulus();
    solveJob(5'd5, 8'sd33, 1'b1, 8'h29);
    solveJob(5'd0, 8'sd1, 1'b1, 8'h27);
    solveJob(5'd1, 8'sd2, 1'b1, 8'h28);
    solveJob(5'd2, -8'sd1, 1'b1, 8'h22);
    solveJob(5'd3, 8'sd127, 1'b1, 8'h23);
    solveJob(5'd4, -8'sd128, 1'b1, 8'h24);
    solveJob(5'd6, 8'sd0, 1'b1, 8'h26);

    // Drain with two jobs in flight
    pushJob(8'h31, bp(8'h31), bo(8'h31));
    takeJob(5'd0, bp(8'h31), bo(8'h31));
    pushJob(8'h32, bp(8'h32), bo(8'h32));
    takeJob(5'd1, bp(8'h32), bo(8'h32));
    pushJob(8'h33, bp(8'h33), bo(8'h33));
    iRUN = 1'b0;
    cycle();
    @(negedge iCLOCK);
    checkOutput("drain_busy", {63'h0, busy}, 64'h1);
    cycle();
    takeJob(5'd2, FILLER_PLAYER, FILLER_OPPONENT);
    solveJob(5'd0, 8'sd5, 1'b1, 8'h31);
    expectResult(8'h32, -8'sd7);
    applyStimulus(1'b0, 1'b1, 5'd1, -8'sd7);
    releaseStimulus();
    @(negedge iCLOCK);
    checkOutput("drain_last_busy", {63'h0, busy}, 64'h1);
    cycle();
    @(negedge iCLOCK);
    checkOutput("idle_busy", {63'h0, busy}, 64'h0);
    checkOutput("idle_sol_enable_lag", {63'h0, sol_enable}, 64'h1);
    cycle();
    @(negedge iCLOCK);
    checkOutput("idle_sol_enable", {63'h0, sol_enable}, 64'h0);
    cycle();

    // Reset mid-operation with queued jobs and a pending result
    iRUN      = 1'b1;
    out_ready = 1'b0;
    cycle();
    takeJob(5'd0, bp(8'h33), bo(8'h33));
    solveJob(5'd0, 8'sd9, 1'b0, 8'h33);
    pushJob(8'h34, bp(8'h34), bo(8'h34));
    pushJob(8'h35, bp(8'h35), bo(8'h35));
    pushJob(8'h36, bp(8'h36), bo(8'h36));
    @(negedge iCLOCK);
    checkOutput("pending_valid", {63'h0, out_valid}, 64'h1);
    #2;
    iRESET_N = 1'b0;
    #1;
    checkOutput("midrst_in_ready", {63'h0, in_ready}, 64'h0);
    checkOutput("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    checkOutput("midrst_busy", {63'h0, busy}, 64'h0);
    cycle();
    iRESET_N  = 1'b1;
    iRUN      = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge iCLOCK);
      checkOutput("post_rst_quiet", {63'h0, out_valid}, 64'h0);
    end
    cycle();
    iRUN = 1'b1;
    cycle();
    takeJob(5'd0, FILLER_PLAYER, FILLER_OPPONENT);
    repeat (3) cycle();

    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
